// File: rtl/seq_stage_controller_if.sv
// Purpose: datapath-facing bundle of the Y86-64 SEQ sequencer (fetch status, data-memory handshake, stage enables).
// Latency: pure wiring, no state.
// Backpressure: mem_ready is the only stall source; the sequencer holds mem_en until it is seen.
// Ports: master = sequencer (drives enables, observes fetch/memory status); slave = datapath (the reverse).
interface seq_stage_controller_if;
    logic [3:0] icode;
    logic       halt;
    logic       imem_error;
    logic       invalid_instr;
    logic       mem_ready;
    logic       dmem_error;
    logic       fetch_en;
    logic       decode_en;
    logic       execute_en;
    logic       mem_en;
    logic       wb_en;
    logic       pc_en;

    modport master (
        input  icode, halt, imem_error, invalid_instr, mem_ready, dmem_error,
        output fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en
    );

    modport slave (
        output icode, halt, imem_error, invalid_instr, mem_ready, dmem_error,
        input  fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en
    );
endinterface

// File: rtl/seq_stage_controller.sv
// Purpose: multi-cycle Y86-64 SEQ stage sequencer with status folding and instruction/cycle counters.
// Latency: 4..6 cycles per instruction with a single-cycle memory, plus extra cycles while mem_ready is low.
// Backpressure: MEMORY waits for mem_ready up to MEM_TIMEOUT cycles, then halts with stat=ADR.
// Ports: clk/rst, start (run request), dp (stage enables + fetch/memory status),
//        busy/done/stat status, instr_count/cycle_count counters.
module seq_stage_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int MAX_INSTR   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    seq_stage_controller_if.master dp,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             stat,
    output logic [CNT_W-1:0]       instr_count,
    output logic [CNT_W-1:0]       cycle_count
);
    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    // Value of the timeout counter during the last MEMORY cycle allowed.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       icode_q, icode_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fetch_en_q, fetch_en_d;
    logic             decode_en_q, decode_en_d;
    logic             execute_en_q, execute_en_d;
    logic             mem_en_q, mem_en_d;
    logic             wb_en_q, wb_en_d;
    logic             pc_en_q, pc_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Loads, stores, call, ret, push and pop touch data memory.
    function automatic logic needs_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // Memory ops that also write a register (mrmovq loads rA, the rest update rsp).
    function automatic logic mem_then_wb(input logic [3:0] ic);
        return ic inside {4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // Register writers that never go through memory: cmov, irmovq, OPq.
    function automatic logic alu_wb(input logic [3:0] ic);
        return ic inside {4'h2, 4'h3, 4'h6};
    endfunction

    always_comb begin
        state_d       = state_q;
        icode_d       = icode_q;
        stat_d        = stat_q;
        instr_count_d = instr_count_q;
        cycle_count_d = cycle_count_q;
        tmo_d         = tmo_q;

        // Count every busy edge, including the one leaving the active states.
        if (state_q != S_IDLE && state_q != S_HALTED) begin
            cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d       = S_FETCH;
                    instr_count_d = '0;
                    cycle_count_d = '0;
                    stat_d        = STAT_AOK;
                    tmo_d         = '0;
                end
            end
            S_FETCH: begin
                icode_d = dp.icode;
                if (dp.imem_error) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else if (dp.invalid_instr) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_INS;
                end else if (dp.halt) begin
                    // halt retires but never reaches PCUPD.
                    state_d       = S_HALTED;
                    stat_d        = STAT_HLT;
                    instr_count_d = instr_count_q + 1'b1;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (needs_mem(icode_q)) begin
                    state_d = S_MEMORY;
                end else if (alu_wb(icode_q)) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_PCUPD;
                end
            end
            S_MEMORY: begin
                if (dp.mem_ready) begin
                    tmo_d = '0;
                    if (dp.dmem_error) begin
                        state_d = S_HALTED;
                        stat_d  = STAT_ADR;
                    end else if (mem_then_wb(icode_q)) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_PCUPD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                instr_count_d = instr_count_q + 1'b1;
                if (MAX_INSTR != 0 && instr_count_d == CNT_W'(MAX_INSTR)) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they track the state register exactly.
        fetch_en_d   = (state_d == S_FETCH);
        decode_en_d  = (state_d == S_DECODE);
        execute_en_d = (state_d == S_EXECUTE);
        mem_en_d     = (state_d == S_MEMORY);
        wb_en_d      = (state_d == S_WRITEBACK);
        pc_en_d      = (state_d == S_PCUPD);
        busy_d       = (state_d != S_IDLE) && (state_d != S_HALTED);
        done_d       = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            icode_q       <= '0;
            stat_q        <= STAT_AOK;
            instr_count_q <= '0;
            cycle_count_q <= '0;
            tmo_q         <= '0;
            fetch_en_q    <= 1'b0;
            decode_en_q   <= 1'b0;
            execute_en_q  <= 1'b0;
            mem_en_q      <= 1'b0;
            wb_en_q       <= 1'b0;
            pc_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            icode_q       <= icode_d;
            stat_q        <= stat_d;
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
            tmo_q         <= tmo_d;
            fetch_en_q    <= fetch_en_d;
            decode_en_q   <= decode_en_d;
            execute_en_q  <= execute_en_d;
            mem_en_q      <= mem_en_d;
            wb_en_q       <= wb_en_d;
            pc_en_q       <= pc_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign dp.fetch_en   = fetch_en_q;
    assign dp.decode_en  = decode_en_q;
    assign dp.execute_en = execute_en_q;
    assign dp.mem_en     = mem_en_q;
    assign dp.wb_en      = wb_en_q;
    assign dp.pc_en      = pc_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign stat          = stat_q;
    assign instr_count   = instr_count_q;
    assign cycle_count   = cycle_count_q;
endmodule
